// File: rtl/cache_nway.sv
`default_nettype none
// ============================================================================
// cache_nway : N-way set-associative cache array with tag compare, tree
//              PLRU, dirty tracking and a write-back port. The optional flush
//              walker is enabled by defining CACHE_NWAY_FLUSH_EN.
// Revision   : 1.0
// ============================================================================
module cache_nway #(
  parameter int WAYS       = 2,
  parameter int SET_BITS   = 5,
  parameter int TAG_BITS   = 23,
  parameter int WORDS      = 4,
  parameter int WORD_BYTES = 4,
  localparam int LINE_W    = WORDS * WORD_BYTES * 8,
  localparam int WAY_W     = $clog2(WAYS),
  localparam int WORD_W    = $clog2(WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [SET_BITS-1:0]   req_set,
  input  logic [TAG_BITS-1:0]   req_tag,
  input  logic [WORD_W-1:0]     req_word,
  input  logic [WORD_BYTES-1:0] req_byte_en,
  input  logic [LINE_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_hit,
  output logic [WAY_W-1:0]      rsp_way,
  output logic [LINE_W-1:0]     rsp_rdata,
  output logic                  evict_valid,
  input  logic                  evict_ready,
  output logic [SET_BITS-1:0]   evict_set,
  output logic [TAG_BITS-1:0]   evict_tag,
  output logic [LINE_W-1:0]     evict_data,
  input  logic                  flush_start,
  output logic                  flush_done
);

  localparam int SETS = 2 ** SET_BITS;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_REFILL = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EVICT = 2'd1
`ifdef CACHE_NWAY_FLUSH_EN
    , ST_FLUSH = 2'd2
`endif
  } state_t;

  state_t state;

  logic [TAG_BITS-1:0] tag_q   [SETS][WAYS];
  logic [LINE_W-1:0]   data_q  [SETS][WAYS];
  logic [WAYS-1:0]     valid_q [SETS];
  logic [WAYS-1:0]     dirty_q [SETS];
  logic [WAYS-2:0]     plru_q  [SETS];

  // Heap-ordered tree: node (2**l - 1 + p) sits at level l, position p.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] bits);
    logic [WAY_W-1:0] w;
    w = '0;
    for (int l = 0; l < WAY_W; l++)
      for (int p = 0; p < (1 << l); p++)
        if (p == int'(w >> (WAY_W - l)))
          w[WAY_W-1-l] = bits[(1 << l) - 1 + p];
    return w;
  endfunction

  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                 input logic [WAY_W-1:0] way);
    logic [WAYS-2:0] r;
    r = bits;
    for (int l = 0; l < WAY_W; l++)
      for (int p = 0; p < (1 << l); p++)
        if (p == int'(way >> (WAY_W - l)))
          r[(1 << l) - 1 + p] = ~way[WAY_W-1-l];
    return r;
  endfunction

  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  victim;
  logic [LINE_W-1:0] hit_line;
  logic [LINE_W-1:0] merged_line;
  logic              victim_dirty;
  logic              accept;
  logic              is_write;
  logic              is_refill;

  always_comb begin
    hit         = 1'b0;
    hit_way     = '0;
    victim      = plru_victim(plru_q[req_set]);
    // Descending scans so the lowest matching / lowest free way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[req_set][w] && (tag_q[req_set][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[req_set][w])
        victim = WAY_W'(w);
    end
    hit_line    = data_q[req_set][hit_way];
    merged_line = hit_line;
    for (int b = 0; b < WORD_BYTES; b++)
      if (req_byte_en[b])
        merged_line[(int'(req_word) * WORD_BYTES + b) * 8 +: 8] = req_wdata[b * 8 +: 8];
  end

  assign victim_dirty = valid_q[req_set][victim] & dirty_q[req_set][victim];
  assign is_write     = (req_op == OP_WRITE);
  assign is_refill    = (req_op == OP_REFILL);
  assign accept       = req_valid & req_ready;

`ifdef CACHE_NWAY_FLUSH_EN
  localparam int IDX_W = SET_BITS + WAY_W;
  logic [IDX_W-1:0]    flush_idx;
  logic                flush_wait;
  logic [SET_BITS-1:0] f_set;
  logic [WAY_W-1:0]    f_way;
  logic                f_last;

  assign f_set     = flush_idx[IDX_W-1:WAY_W];
  assign f_way     = flush_idx[WAY_W-1:0];
  assign f_last    = (flush_idx == {IDX_W{1'b1}});
  assign req_ready = (state == ST_IDLE) && !flush_start;
`else
  logic unused_flush_start;
  assign unused_flush_start = flush_start;
  assign req_ready          = (state == ST_IDLE);
  assign flush_done         = 1'b0;
`endif

  // Tag and data arrays carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (accept && is_refill) begin
      tag_q[req_set][victim]  <= req_tag;
      data_q[req_set][victim] <= req_wdata;
    end else if (accept && is_write && hit) begin
      data_q[req_set][hit_way] <= merged_line;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      rsp_valid   <= 1'b0;
      rsp_hit     <= 1'b0;
      rsp_way     <= '0;
      rsp_rdata   <= '0;
      evict_valid <= 1'b0;
      evict_set   <= '0;
      evict_tag   <= '0;
      evict_data  <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
`ifdef CACHE_NWAY_FLUSH_EN
      flush_done <= 1'b0;
      flush_idx  <= '0;
      flush_wait <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
`ifdef CACHE_NWAY_FLUSH_EN
      flush_done <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
`ifdef CACHE_NWAY_FLUSH_EN
          if (flush_start) begin
            state      <= ST_FLUSH;
            flush_idx  <= '0;
            flush_wait <= 1'b0;
          end else
`endif
          if (req_valid) begin
            rsp_valid <= 1'b1;
            if (is_refill) begin
              rsp_hit                   <= 1'b1;
              rsp_way                   <= victim;
              rsp_rdata                 <= req_wdata;
              valid_q[req_set][victim]  <= 1'b1;
              dirty_q[req_set][victim]  <= 1'b0;
              plru_q[req_set]           <= plru_touch(plru_q[req_set], victim);
              if (victim_dirty) begin
                evict_valid <= 1'b1;
                evict_set   <= req_set;
                evict_tag   <= tag_q[req_set][victim];
                evict_data  <= data_q[req_set][victim];
                state       <= ST_EVICT;
              end
            end else begin
              rsp_hit   <= hit;
              rsp_way   <= hit ? hit_way : '0;
              rsp_rdata <= hit ? (is_write ? merged_line : hit_line) : '0;
              if (hit) begin
                plru_q[req_set] <= plru_touch(plru_q[req_set], hit_way);
                if (is_write)
                  dirty_q[req_set][hit_way] <= 1'b1;
              end
            end
          end
        end

        ST_EVICT: begin
          if (evict_ready) begin
            evict_valid <= 1'b0;
            state       <= ST_IDLE;
          end
        end

`ifdef CACHE_NWAY_FLUSH_EN
        ST_FLUSH: begin
          if (flush_wait) begin
            if (evict_ready) begin
              evict_valid           <= 1'b0;
              flush_wait            <= 1'b0;
              dirty_q[f_set][f_way] <= 1'b0;
              if (f_last) begin
                flush_done <= 1'b1;
                state      <= ST_IDLE;
              end else begin
                flush_idx <= flush_idx + 1'b1;
              end
            end
          end else if (valid_q[f_set][f_way] && dirty_q[f_set][f_way]) begin
            evict_valid <= 1'b1;
            evict_set   <= f_set;
            evict_tag   <= tag_q[f_set][f_way];
            evict_data  <= data_q[f_set][f_way];
            flush_wait  <= 1'b1;
          end else if (f_last) begin
            flush_done <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            flush_idx <= flush_idx + 1'b1;
          end
        end
`endif

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/cache_nway.md
# cache_nway

Parametrised N-way set-associative cache storage with built-in tag compare, tree pseudo-LRU replacement, dirty tracking and a dirty-line write-back port. It is the next-generation storage block below the cache controller. Replacement choice, hit detection and evictions move into the array, so the controller only issues read, write and refill operations and drains evictions. An optional flush walker writes back every dirty line.

## Interface

**Parameters**
- `WAYS`, 2 — associativity; power of two, 2..8.
- `SET_BITS`, 5 — index width; `SETS = 2**SET_BITS`.
- `TAG_BITS`, 23 — tag width.
- `WORDS`, 4 — words per line; power of two.
- `WORD_BYTES`, 4 — bytes per word.
- Derived widths:
  - `LINE_W = WORDS*WORD_BYTES*8`.
  - `WAY_W = $clog2(WAYS)`.
  - `WORD_W = $clog2(WORDS)`.

**Ports**
- `clk` in 1 — clock; single clock domain.
- `rst` in 1 — asynchronous reset, active-high.
- `req_valid` in 1 — request present.
- `req_ready` out 1 — request accepted when `req_valid & req_ready`.
- `req_op` in 2 — operation: 00 read, 01 write, 10 refill, 11 reserved (treated as read).
- `req_set` in SET_BITS — set index.
- `req_tag` in TAG_BITS — tag.
- `req_word` in WORD_W — word select for writes.
- `req_byte_en` in WORD_BYTES — byte enables for writes.
- `req_wdata` in LINE_W — full line for refill; bits [WORD_BYTES*8-1:0] for write.
- `rsp_valid` out 1 — one-cycle response pulse.
- `rsp_hit` out 1 — tag matched in a valid way (refill: always 1).
- `rsp_way` out WAY_W — hit way, or victim way for refill.
- `rsp_rdata` out LINE_W — line contents of the hit way; 0 on miss.
- `evict_valid` out 1 — dirty victim line presented.
- `evict_ready` in 1 — downstream accepts the eviction.
- `evict_set` out SET_BITS — set of the evicted line.
- `evict_tag` out TAG_BITS — tag of the evicted line.
- `evict_data` out LINE_W — data of the evicted line.
- `flush_start` in 1 — start a flush walk.
- `flush_done` out 1 — one-cycle pulse when the flush walk completes.

## Operation

**Storage and reset**
- Storage is flop-based, per set/way: tag, valid, dirty and line data. Each set also holds `WAYS-1` PLRU bits.
- Reset clears all valid, dirty and PLRU bits. Data and tag contents are not reset.

**States**
- IDLE: `req_ready = ~flush_start`. `flush_start` has priority over a request in the same cycle.
- EVICT: `evict_valid` held with stable outputs until `evict_ready`, then return to IDLE. `req_ready = 0`.
- FLUSH: walk `idx = set*WAYS + way` from 0. Skip clean or invalid lines at one line per cycle. For a valid dirty line, present it as an eviction, wait for `evict_ready`, then clear its dirty bit; the valid bit is kept. After the last index, pulse `flush_done` and go to IDLE. `req_ready = 0`.

**Read**
- Hit: return the line and update the PLRU bits for that set.
- Miss: `rsp_hit = 0`; no state change.

**Write**
- Hit: merge `req_byte_en` bytes into word `req_word`, set dirty, update PLRU.
- Miss: no state change. Allocation is done by the controller as a refill followed by a write.

**Refill**
- Victim selection:
  - The lowest-index invalid way, if any.
  - Otherwise the way chosen by the PLRU.
- Effects: write tag and line, set valid = 1 and dirty = 0, update PLRU.
- If the old victim was valid and dirty:
  - Present its set, tag and data on the evict port in the same cycle as `rsp_valid`.
  - Enter EVICT.

**PLRU**
- Tree of `WAYS-1` bits; node bit 0 means the victim is in the lower half.
- On an access, every node on the accessed way's path is set to point away from it.

**Multiple tag matches** cannot occur through legal use. If they do, the lowest way wins.

## Timing

- The request is accepted on a clock edge. `rsp_*` is registered and valid exactly one cycle later for one cycle.
- Array, dirty and PLRU updates become visible to the next request. Back-to-back requests, one per cycle, are allowed in IDLE.
- `evict_*` outputs are registered. Held while `evict_valid & ~evict_ready`.
- Reset values:
  - `req_ready = 1`.
  - `rsp_valid = 0`, `rsp_hit = 0`, `rsp_way = 0`, `rsp_rdata = 0`.
  - `evict_valid = 0`; `evict_set`, `evict_tag`, `evict_data` = 0.
  - `flush_done = 0`.
  - State = IDLE.
- Reset mid-EVICT or mid-FLUSH abandons the operation immediately. The pending eviction is lost and all lines become invalid.
- A flush over `SETS*WAYS` clean lines takes `SETS*WAYS` cycles, plus one cycle for the `flush_done` pulse.

## Configuration

- `CACHE_NWAY_FLUSH_EN` defined: FLUSH state, walker counter and `flush_done` are implemented as described above.
- `CACHE_NWAY_FLUSH_EN` undefined:
  - No FLUSH state is implemented.
  - `flush_start` is ignored and `req_ready` does not depend on it.
  - `flush_done` is tied to 0.

## Test plan

- Reset, then read at set 3, tag 0x12 -> next cycle `rsp_valid = 1`, `rsp_hit = 0`, `rsp_rdata = 0`, `evict_valid = 0`.
- Refill at set 3, tag 0x12 with line 0x0123...CDEF, then read the same address -> `rsp_hit = 1`, `rsp_way = 0`, `rsp_rdata` equals the written line.
- Write at set 3, tag 0x12, `req_word = 2`, `req_byte_en = 4'b0101`, data 0xAABBCCDD -> subsequent read shows word 2 with bytes 0 and 2 replaced by DD and BB only.
- `WAYS = 2`:
  1. Refill tags A and B into set 3, write tag A (dirty), read tag B.
  2. Refill tag C.
  3. Expect: victim is the way holding A; `evict_valid = 1` with `evict_tag = A`; `req_ready = 0` until `evict_ready` is asserted.
- Hold `evict_ready = 0` for 5 cycles during EVICT -> `evict_*` stable and no request accepted. `evict_ready = 1` -> IDLE on the next cycle.
- With `CACHE_NWAY_FLUSH_EN`, two dirty lines at indices 7 and 40, pulse `flush_start` ->
  - Two evictions in index order.
  - Dirty bits cleared; both lines still hit.
  - `flush_done` pulses once after index `SETS*WAYS-1`.
